// File: rtl/serial_mult_arbiter.sv
// Round-robin arbiter sharing one serial shift-add multiplier core among NUM_REQ requesters,
// with a watchdog that aborts an operation whose core result never arrives.
module serial_mult_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic                     resp_err,
    output logic                     busy,
    output logic                     mult_valid,
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    input  logic                     mult_product_valid,
    input  logic [2*WIDTH-1:0]       mult_product
);

    localparam int unsigned NR   = NUM_REQ;
    localparam int          WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [WD_W-1:0]     r_wd;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [ID_W-1:0]     r_resp_id;
    logic [2*WIDTH-1:0]  r_resp_product;

    logic                w_found;
    logic [ID_W-1:0]     w_gid;
    logic                w_accept;
    logic                w_timeout;
    logic [WIDTH-1:0]    w_ga;
    logic [WIDTH-1:0]    w_gb;

    // Scan offsets from the far end down so the nearest requester after the pointer wins.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_gid   = '0;
        idx     = 0;
        for (int unsigned k = NR; k >= 1; k--) begin
            idx = (32'(r_ptr) + k) % NR;
            if (req_valid[idx]) begin
                w_found = 1'b1;
                w_gid   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_ga = req_a[w_gid*WIDTH +: WIDTH];
        w_gb = req_b[w_gid*WIDTH +: WIDTH];
    end

    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign w_timeout = (r_wd == WD_W'(TIMEOUT - 1));
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_gid) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (mult_product_valid || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= ID_W'(NUM_REQ - 1);
            r_id           <= '0;
            r_wd           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_err     <= 1'b0;
            r_resp_id      <= '0;
            r_resp_product <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_id    <= '0;
            if (w_accept) begin
                r_a   <= w_ga;
                r_b   <= w_gb;
                r_id  <= w_gid;
                r_ptr <= w_gid;
            end
            // A real product beats a coincident timeout.
            if (r_state == S_WAIT) begin
                if (mult_product_valid) begin
                    r_resp_product <= mult_product;
                    r_resp_valid   <= 1'b1;
                    r_resp_id      <= r_id;
                    r_wd           <= '0;
                end else if (w_timeout) begin
                    r_resp_product <= '0;
                    r_resp_valid   <= 1'b1;
                    r_resp_err     <= 1'b1;
                    r_resp_id      <= r_id;
                    r_wd           <= '0;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_err     = r_resp_err;
    assign resp_id      = r_resp_id;
    assign resp_product = r_resp_product;
    assign busy         = (r_state != S_IDLE);
    assign mult_valid   = (r_state == S_ISSUE);
    assign mult_a       = r_a;
    assign mult_b       = r_b;

endmodule
